// File: rtl/buzzer_sos_sequencer.sv
// SOS buzzer sequencer: three short, three long, three short tones with a gap after
// each, optional periodic re-run after a rest interval, one-cycle start / abort control.
module buzzer_sos_sequencer #(
    parameter logic [27:0] T_SHORT = 28'd5_000_000,
    parameter logic [27:0] T_LONG  = 28'd15_000_000,
    parameter logic [27:0] T_GAP   = 28'd2_500_000,
    parameter logic [27:0] T_REST  = 28'd52_500_000
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Repeat,
    output logic       Buzzer_En,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] Symbol_Idx
);

    localparam int unsigned CNT_W = 28;
    localparam int unsigned SYM_W = 4;
    localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_REST = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SYM_W-1:0]   r_sym;
    logic [SYM_W-1:0]   w_sym_nxt;
    logic               w_done_nxt;
    logic               w_buz_nxt;
    logic               w_busy_nxt;
    logic               w_cnt_zero;
    logic [CNT_W-1:0]   w_tone_len;

    assign w_cnt_zero = (r_cnt == '0);

    // State, counter and registered outputs
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sym      <= '0;
            Buzzer_En  <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Symbol_Idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sym      <= w_sym_nxt;
            Buzzer_En  <= w_buz_nxt;
            Busy       <= w_busy_nxt;
            Done       <= w_done_nxt;
            Symbol_Idx <= w_sym_nxt;
        end
    end

    // Next state; Stop overrides everything, including the end-of-pattern Done
    always_comb begin
        w_state_nxt = r_state;
        w_sym_nxt   = r_sym;
        w_done_nxt  = 1'b0;
        if (Stop) begin
            w_state_nxt = S_IDLE;
            w_sym_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        w_state_nxt = S_ON;
                        w_sym_nxt   = '0;
                    end
                end
                S_ON: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = S_OFF;
                    end
                end
                S_OFF: begin
                    if (w_cnt_zero) begin
                        if (r_sym == LAST_SYM) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = Repeat ? S_REST : S_IDLE;
                            w_sym_nxt   = '0;
                        end else begin
                            w_state_nxt = S_ON;
                            w_sym_nxt   = r_sym + SYM_W'(1);
                        end
                    end
                end
                S_REST: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = S_ON;
                        w_sym_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_sym_nxt   = '0;
                end
            endcase
        end
    end

    // Output and counter values for the next cycle; counter reloads on every state entry
    always_comb begin
        w_buz_nxt  = (w_state_nxt == S_ON);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_tone_len = ((w_sym_nxt >= SYM_W'(3)) && (w_sym_nxt <= SYM_W'(5))) ? T_LONG : T_SHORT;
        w_cnt_nxt  = r_cnt;
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                S_ON:    w_cnt_nxt = w_tone_len - CNT_W'(1);
                S_OFF:   w_cnt_nxt = T_GAP - CNT_W'(1);
                S_REST:  w_cnt_nxt = T_REST - CNT_W'(1);
                default: w_cnt_nxt = '0;
            endcase
        end else if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_buzzer_sos_sequencer.sv
// Bench for buzzer_sos_sequencer: directed scenarios plus random Start/Stop/Repeat traffic,
// every cycle compared against a timeline-based model of the SOS pattern.
module tb_buzzer_sos_sequencer;

    localparam int unsigned TS = 4;
    localparam int unsigned TL = 12;
    localparam int unsigned TG = 2;
    localparam int unsigned TR = 10;

    logic       CLK;
    logic       RST_n;
    logic       Start;
    logic       Stop;
    logic       Repeat;
    logic       Buzzer_En;
    logic       Busy;
    logic       Done;
    logic [3:0] Symbol_Idx;

    int chk_cnt;
    int err_cnt;
    int done_seen;
    bit rep_lvl;

    // Model: pattern flattened to a per-cycle timeline, plus mode and position
    bit tl_on[$];
    int tl_sym[$];
    int m_mode;  // 0 idle, 1 pattern, 2 rest
    int m_p;
    bit m_done;

    buzzer_sos_sequencer #(
        .T_SHORT(28'(TS)),
        .T_LONG (28'(TL)),
        .T_GAP  (28'(TG)),
        .T_REST (28'(TR))
    ) u_dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Start     (Start),
        .Stop      (Stop),
        .Repeat    (Repeat),
        .Buzzer_En (Buzzer_En),
        .Busy      (Busy),
        .Done      (Done),
        .Symbol_Idx(Symbol_Idx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic build_timeline();
        for (int s = 0; s < 9; s++) begin
            int len;
            len = (s >= 3 && s <= 5) ? TL : TS;
            for (int k = 0; k < len; k++) begin
                tl_on.push_back(1'b1);
                tl_sym.push_back(s);
            end
            for (int k = 0; k < TG; k++) begin
                tl_on.push_back(1'b0);
                tl_sym.push_back(s);
            end
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_p    = 0;
        m_done = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit rp);
        m_done = 1'b0;
        if (sp) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (st) begin
                m_mode = 1;
                m_p    = 0;
            end
        end else if (m_mode == 1) begin
            if (m_p == tl_on.size() - 1) begin
                m_done = 1'b1;
                m_mode = rp ? 2 : 0;
                m_p    = 0;
            end else begin
                m_p++;
            end
        end else begin
            if (m_p == TR - 1) begin
                m_mode = 1;
                m_p    = 0;
            end else begin
                m_p++;
            end
        end
    endtask

    task automatic check_outputs();
        bit e_buz;
        int e_sym;
        e_buz = (m_mode == 1) && tl_on[m_p];
        e_sym = (m_mode == 1) ? tl_sym[m_p] : 0;
        check("buzzer", 32'(Buzzer_En), 32'(e_buz));
        check("busy", 32'(Busy), 32'(m_mode != 0));
        check("done", 32'(Done), 32'(m_done));
        check("sym", 32'(Symbol_Idx), 32'(e_sym));
    endtask

    // Drive inputs at negedge, let DUT and model see them at posedge, check at next negedge
    task automatic cycle(input bit st, input bit sp);
        Start  = st;
        Stop   = sp;
        Repeat = rep_lvl;
        @(posedge CLK);
        model_step(st, sp, rep_lvl);
        @(negedge CLK);
        check_outputs();
        if (Done) done_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        chk_cnt   = 0;
        err_cnt   = 0;
        done_seen = 0;
        rep_lvl   = 1'b0;
        Start     = 1'b0;
        Stop      = 1'b0;
        Repeat    = 1'b0;
        RST_n     = 1'b0;
        build_timeline();
        model_reset();
        check("pattern_len", 32'(tl_on.size()), 32'(6 * TS + 3 * TL + 9 * TG));
        #12;
        check("rst_buzzer", 32'(Buzzer_En), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_sym", 32'(Symbol_Idx), 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        idle(2);

        // Single pattern, no repeat
        done_seen = 0;
        cycle(1'b1, 1'b0);
        idle(85);
        check("single_done_cnt", 32'(done_seen), 32'd1);

        // Repeat mode: two full patterns, then stop during rest
        rep_lvl   = 1'b1;
        done_seen = 0;
        cycle(1'b1, 1'b0);
        idle(170);
        check("repeat_done_cnt", 32'(done_seen), 32'd2);
        rep_lvl = 1'b0;
        cycle(1'b0, 1'b1);
        idle(3);

        // Start pulses mid-run are ignored
        done_seen = 0;
        for (int c = 0; c < 90; c++) cycle(c == 0 || c == 10 || c == 50, 1'b0);
        check("ignore_start_done_cnt", 32'(done_seen), 32'd1);

        // Stop inside a long tone, then a full run
        done_seen = 0;
        for (int c = 0; c < 35; c++) cycle(c == 0, c == 30);
        check("stop_mid_done_cnt", 32'(done_seen), 32'd0);
        for (int c = 0; c < 85; c++) cycle(c == 0, 1'b0);
        check("after_stop_done_cnt", 32'(done_seen), 32'd1);

        // Stop in the last gap cycle suppresses Done, even with Repeat set
        done_seen = 0;
        rep_lvl   = 1'b1;
        for (int c = 0; c < 85; c++) cycle(c == 0, c == 78);
        check("stop_last_done_cnt", 32'(done_seen), 32'd0);
        rep_lvl = 1'b0;

        // Start and Stop together in idle
        cycle(1'b1, 1'b1);
        idle(3);

        // Asynchronous reset mid-tone
        for (int c = 0; c < 8; c++) cycle(c == 0, 1'b0);
        #2;
        RST_n = 1'b0;
        #1;
        check("arst_buzzer", 32'(Buzzer_En), 32'd0);
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_done", 32'(Done), 32'd0);
        check("arst_sym", 32'(Symbol_Idx), 32'd0);
        model_reset();
        #1;
        RST_n = 1'b1;
        idle(10);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            bit st;
            bit sp;
            st = ($urandom_range(0, 29) == 0);
            sp = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) rep_lvl = ~rep_lvl;
            cycle(st, sp);
        end

        $display("test done: total=%0d bad=%0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
